// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that time-shares one 4-bit ALU between NREQ clients.
// It issues one operation at a time and returns the captured result tagged with the requester id.
module alu_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [4*NREQ-1:0]   req_a,
    input  logic [4*NREQ-1:0]   req_b,
    input  logic [3*NREQ-1:0]   req_op,
    output logic [3:0]          alu_a,
    output logic [3:0]          alu_b,
    output logic [2:0]          alu_opcode,
    input  logic [7:0]          alu_c,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDW-1:0]      resp_id,
    output logic [7:0]          resp_c,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0]     CNT_INIT  = 3'(ALU_LAT - 1);
    localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

    state_t           state_r;
    state_t           state_nx_s;
    logic [2:0]       cnt_r;
    logic [IDW-1:0]   last_grant_r;
    logic [3:0]       alu_a_r;
    logic [3:0]       alu_b_r;
    logic [2:0]       alu_op_r;
    logic             resp_valid_r;
    logic [IDW-1:0]   resp_id_r;
    logic [7:0]       resp_c_r;
    logic             busy_r;

    logic             found_s;
    logic [IDW-1:0]   winner_s;
    int               dist_s;
    int               best_s;
    logic             hit_s;
    logic [3:0]       win_a_s;
    logic [3:0]       win_b_s;
    logic [2:0]       win_op_s;
    logic             load_s;
    logic             capture_s;
    logic             release_s;

    // Round-robin search: the valid requester closest after last_grant wins.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        best_s   = NREQ;
        dist_s   = 0;
        hit_s    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            dist_s   = (i + NREQ - 1 - int'(last_grant_r)) % NREQ;
            hit_s    = req_valid[i] && (dist_s < best_s);
            best_s   = hit_s ? dist_s : best_s;
            winner_s = hit_s ? IDW'(i) : winner_s;
            found_s  = found_s | hit_s;
        end
    end

    // Select the winner's operand slices.
    always_comb begin
        win_a_s  = 4'd0;
        win_b_s  = 4'd0;
        win_op_s = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            win_a_s  = (winner_s == IDW'(i)) ? req_a[4*i +: 4]  : win_a_s;
            win_b_s  = (winner_s == IDW'(i)) ? req_b[4*i +: 4]  : win_b_s;
            win_op_s = (winner_s == IDW'(i)) ? req_op[3*i +: 3] : win_op_s;
        end
    end

    // Grant is combinational and only offered while idle and out of reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = reset && (state_r == ST_IDLE) && found_s && (winner_s == IDW'(i));
        end
    end

    // Next-state decode and the strobes that steer the datapath registers.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        capture_s  = 1'b0;
        release_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_nx_s = ST_EXEC;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == 3'd0) begin
                    state_nx_s = ST_RESP;
                    capture_s  = 1'b1;
                end else begin
                    state_nx_s = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_nx_s = ST_IDLE;
                    release_s  = 1'b1;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand, counter and response registers; operands persist between operations.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r        <= 3'd0;
            last_grant_r <= LAST_INIT;
            alu_a_r      <= 4'd0;
            alu_b_r      <= 4'd0;
            alu_op_r     <= 3'd0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= '0;
            resp_c_r     <= 8'd0;
            busy_r       <= 1'b0;
        end else begin
            if (load_s) begin
                alu_a_r      <= win_a_s;
                alu_b_r      <= win_b_s;
                alu_op_r     <= win_op_s;
                resp_id_r    <= winner_s;
                last_grant_r <= winner_s;
                cnt_r        <= CNT_INIT;
            end else if ((state_r == ST_EXEC) && (cnt_r != 3'd0)) begin
                cnt_r <= cnt_r - 3'd1;
            end
            if (capture_s) begin
                resp_c_r     <= alu_c;
                resp_valid_r <= 1'b1;
            end else if (release_s) begin
                resp_valid_r <= 1'b0;
            end
            busy_r <= (state_nx_s != ST_IDLE);
        end
    end

    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_opcode = alu_op_r;
    assign resp_valid = resp_valid_r;
    assign resp_id    = resp_id_r;
    assign resp_c     = resp_c_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: two instances (ALU latency 1 and 3) share stimulus and are
// compared every cycle against a transaction-level reference model.
module tb_alu_req_arbiter;

    localparam int N    = 4;
    localparam int W    = 2;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [4*N-1:0]   req_a;
    logic [4*N-1:0]   req_b;
    logic [3*N-1:0]   req_op;
    logic             resp_ready;

    logic [N-1:0]     rr  [2];
    logic [3:0]       aa  [2];
    logic [3:0]       ab  [2];
    logic [2:0]       aop [2];
    logic [7:0]       ac  [2];
    logic             rv  [2];
    logic [W-1:0]     rid [2];
    logic [7:0]       rc  [2];
    logic             bsy [2];

    int errs   = 0;
    int checks = 0;

    // Reference model state, one slot per instance.
    int          m_busy [2];
    int          m_t    [2];
    int          m_rv   [2];
    int          m_last [2];
    int          m_id   [2];
    logic [3:0]  m_aa   [2];
    logic [3:0]  m_ab   [2];
    logic [2:0]  m_aop  [2];
    logic [7:0]  m_rc   [2];
    int          gl0 [$];
    int          gl1 [$];

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return {4'd0, a} + {4'd0, b};
            3'd1:    return {4'd0, a} - {4'd0, b};
            3'd2:    return {4'd0, a & b};
            3'd3:    return {4'd0, a | b};
            3'd4:    return {4'd0, a ^ b};
            3'd5:    return {4'd0, a} * {4'd0, b};
            3'd6:    return {a, b};
            default: return ~{a, b};
        endcase
    endfunction

    assign ac[0] = alu_f(aa[0], ab[0], aop[0]);
    assign ac[1] = alu_f(aa[1], ab[1], aop[1]);

    alu_req_arbiter #(.NREQ(N), .IDW(W), .ALU_LAT(LAT0)) u_lat1 (
        .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(rr[0]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(aa[0]), .alu_b(ab[0]), .alu_opcode(aop[0]), .alu_c(ac[0]),
        .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_id(rid[0]), .resp_c(rc[0]),
        .busy(bsy[0])
    );

    alu_req_arbiter #(.NREQ(N), .IDW(W), .ALU_LAT(LAT1)) u_lat3 (
        .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(rr[1]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(aa[1]), .alu_b(ab[1]), .alu_opcode(aop[1]), .alu_c(ac[1]),
        .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_id(rid[1]), .resp_c(rc[1]),
        .busy(bsy[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic string tg(input string s, input int k);
        return $sformatf("%s_i%0d", s, k);
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    // First valid requester after 'last', wrapping; -1 when none is valid.
    function automatic int pick(input int last);
        int idx;
        for (int s = 1; s <= N; s++) begin
            idx = (last + s) % N;
            if (req_valid[idx[W-1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic void m_reset(input int k);
        m_busy[k] = 0;
        m_t[k]    = 0;
        m_rv[k]   = 0;
        m_last[k] = N - 1;
        m_id[k]   = 0;
        m_aa[k]   = 4'd0;
        m_ab[k]   = 4'd0;
        m_aop[k]  = 3'd0;
        m_rc[k]   = 8'd0;
    endfunction

    function automatic int glog_size(input int k);
        return (k == 0) ? gl0.size() : gl1.size();
    endfunction

    function automatic int glog_at(input int k, input int i);
        return (k == 0) ? gl0[i] : gl1[i];
    endfunction

    // Compare both instances against the model for this cycle, then advance the model over the next edge.
    task automatic tick();
        int w;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) m_reset(k);
            w = (!rst_n || (m_busy[k] != 0)) ? -1 : pick(m_last[k]);
            check_val(tg("req_ready", k), 32'(rr[k]), (w < 0) ? 32'd0 : (32'd1 << w));
            check_val(tg("busy", k), 32'(bsy[k]), 32'(m_busy[k]));
            check_val(tg("resp_valid", k), 32'(rv[k]), 32'(m_rv[k]));
            check_val(tg("resp_id", k), 32'(rid[k]), 32'(m_id[k]));
            check_val(tg("resp_c", k), 32'(rc[k]), 32'(m_rc[k]));
            check_val(tg("alu_a", k), 32'(aa[k]), 32'(m_aa[k]));
            check_val(tg("alu_b", k), 32'(ab[k]), 32'(m_ab[k]));
            check_val(tg("alu_op", k), 32'(aop[k]), 32'(m_aop[k]));
            if (rst_n) begin
                if (w >= 0) begin
                    m_busy[k] = 1;
                    m_t[k]    = 0;
                    m_id[k]   = w;
                    m_last[k] = w;
                    m_aa[k]   = 4'(req_a >> (4 * w));
                    m_ab[k]   = 4'(req_b >> (4 * w));
                    m_aop[k]  = 3'(req_op >> (3 * w));
                    if (k == 0) gl0.push_back(w);
                    else        gl1.push_back(w);
                end else if ((m_busy[k] != 0) && (m_rv[k] == 0)) begin
                    m_t[k]++;
                    if (m_t[k] == lat_of(k)) begin
                        m_rv[k] = 1;
                        m_rc[k] = alu_f(m_aa[k], m_ab[k], m_aop[k]);
                    end
                end else if ((m_rv[k] != 0) && resp_ready) begin
                    m_rv[k]   = 0;
                    m_busy[k] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic tb_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        gl0.delete();
        gl1.delete();
    endtask

    task automatic rand_operands();
        req_a  = 16'($urandom);
        req_b  = 16'($urandom);
        req_op = 12'($urandom);
    endtask

    initial begin
        int n2;
        rst_n      = 1'b0;
        req_valid  = 4'b0000;
        req_a      = 16'h0000;
        req_b      = 16'h0000;
        req_op     = 12'h000;
        resp_ready = 1'b1;
        m_reset(0);
        m_reset(1);
        @(negedge clk);
        req_valid = 4'b1111;
        tick();
        tick();
        req_valid = 4'b0000;
        rst_n = 1'b1;
        tick();

        // Single request to requester 2: F + 1 = 8'h10.
        req_valid = 4'b0100;
        req_a     = 16'h0F00;
        req_b     = 16'h0100;
        req_op    = 12'h000;
        #1 check_val("single_ready", 32'(rr[0]), 32'h4);
        tick();
        req_valid = 4'b0000;
        tick();
        #1;
        check_val("single_rv", 32'(rv[0]), 32'h1);
        check_val("single_c", 32'(rc[0]), 32'h10);
        check_val("single_id", 32'(rid[0]), 32'h2);
        check_val("single_alu_a", 32'(aa[0]), 32'hF);
        repeat (6) tick();

        // Round-robin fairness with everyone requesting.
        tb_reset();
        req_valid = 4'b1111;
        rand_operands();
        repeat (34) tick();
        for (int k = 0; k < 2; k++) begin
            check_val(tg("fair_cnt", k), 32'(glog_size(k) >= 6), 32'd1);
            for (int i = 0; i < 6; i++) begin
                if (i < glog_size(k)) check_val(tg($sformatf("fair%0d", i), k), 32'(glog_at(k, i)), 32'(i % 4));
            end
        end

        // Wrap from 3 and skip idle requesters.
        tb_reset();
        req_valid = 4'b1000;
        tick();
        gl0.delete();
        gl1.delete();
        req_valid = 4'b1010;
        repeat (14) tick();
        for (int k = 0; k < 2; k++) begin
            check_val(tg("wrap_cnt", k), 32'(glog_size(k) >= 2), 32'd1);
            if (glog_size(k) >= 2) begin
                check_val(tg("wrap_first", k), 32'(glog_at(k, 0)), 32'd1);
                check_val(tg("wrap_second", k), 32'(glog_at(k, 1)), 32'd3);
            end
        end

        // Response backpressure with requester 0 waiting.
        tb_reset();
        resp_ready = 1'b0;
        req_valid  = 4'b0001;
        rand_operands();
        repeat (10) tick();
        #1;
        check_val("bp_hold_rv", 32'(rv[1]), 32'd1);
        check_val("bp_grants0", 32'(gl0.size()), 32'd1);
        check_val("bp_grants1", 32'(gl1.size()), 32'd1);
        resp_ready = 1'b1;
        repeat (3) tick();
        check_val("bp_regrant", 32'(gl1.size()), 32'd2);

        // Reset during the second EXEC cycle of the latency-3 instance.
        tb_reset();
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        gl0.delete();
        gl1.delete();
        repeat (6) tick();
        req_valid = 4'b1111;
        #1 check_val("rst_prio", 32'(rr[1]), 32'h1);
        tick();
        check_val("rst_grant", 32'(gl1.size()), 32'd1);

        // Early withdrawal: requester 2 only asks while the block is in RESP.
        tb_reset();
        resp_ready = 1'b0;
        req_valid  = 4'b0001;
        tick();
        req_valid = 4'b0000;
        repeat (6) tick();
        req_valid = 4'b0100;
        repeat (3) tick();
        req_valid  = 4'b0000;
        resp_ready = 1'b1;
        repeat (8) tick();
        n2 = 0;
        foreach (gl0[i]) if (gl0[i] == 2) n2++;
        foreach (gl1[i]) if (gl1[i] == 2) n2++;
        check_val("wd_no_grant2", 32'(n2), 32'd0);
        check_val("wd_grants", 32'(gl0.size() + gl1.size()), 32'd2);

        // Randomized traffic with occasional resets.
        tb_reset();
        repeat (3000) begin
            req_valid  = 4'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            rst_n      = ($urandom_range(0, 299) != 0);
            rand_operands();
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one 4-bit ALU datapath (operands a, b, 3-bit opcode, 8-bit result c) between NREQ requesters.
- Arbitration is round-robin.
- Sequences one operation at a time: accept request, drive the ALU operands, wait a fixed ALU latency, capture c, and return it tagged with the requester id.
- Sits between client blocks and the ALU instance; it is the only driver of the ALU's a/b/opcode inputs.

Parameters:
- NREQ, default 4, number of requesters (2..8).
- IDW, default 2, width of the requester id; must satisfy 2**IDW >= NREQ.
- ALU_LAT, default 1, clock edges from operand drive to result capture (1..7).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant/accept; at most one bit high; combinational.
- req_a  input  4*NREQ  operand a; slice i belongs to requester i.
- req_b  input  4*NREQ  operand b; slice i belongs to requester i.
- req_op  input  3*NREQ  opcode; slice i belongs to requester i.
- alu_a  output  4  registered operand to the ALU.
- alu_b  output  4  registered operand to the ALU.
- alu_opcode  output  3  registered opcode to the ALU.
- alu_c  input  8  ALU result.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  IDW  index of the requester that issued the result.
- resp_c  output  8  captured result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset (reset=0, asynchronous):
  - state=IDLE; exec counter=0; last_grant=NREQ-1, so requester 0 has top priority after reset.
  - alu_a=0, alu_b=0, alu_opcode=0, resp_valid=0, resp_id=0, resp_c=0, busy=0.
  - req_ready=0 while reset is asserted.
- IDLE:
  - The winner is the first i with req_valid[i]=1, searching from (last_grant+1) mod NREQ upward with wrap.
  - req_ready[winner]=1 in the same cycle; all other req_ready bits are 0.
  - The handshake completes on that rising edge. At that edge: alu_a/alu_b/alu_opcode load the winner's slices, resp_id loads the winner index, last_grant loads the winner, the counter loads ALU_LAT-1, and state goes to EXEC.
  - No req_valid bit high: stay in IDLE, all req_ready=0.
- EXEC:
  - req_ready=0; ALU operand registers hold.
  - Counter decrements each edge.
  - On the edge where the counter equals 0: resp_c<=alu_c, resp_valid<=1, state goes to RESP.
  - resp_valid therefore rises ALU_LAT edges after the handshake edge.
- RESP:
  - resp_valid=1; resp_c and resp_id are stable until accepted; req_ready=0.
  - resp_valid&resp_ready at an edge: resp_valid<=0, state goes to IDLE.
  - The next grant is possible in the cycle after that edge.
  - Minimum issue-to-issue spacing is ALU_LAT+2 cycles.
- alu_a/alu_b/alu_opcode retain the last issued values between operations; they are not cleared after use.
- Requesters may drop req_valid at any time before their grant; a dropped request is not recorded.
- req_valid changes in EXEC or RESP are ignored. Arbitration happens only in IDLE, using that cycle's req_valid.
- Opcode and operand values are passed through unmodified; the block does not decode or check opcodes.
- Out-of-range id: with NREQ < 2**IDW, no resp_id value >= NREQ is ever produced.
- Reset asserted mid-EXEC or mid-RESP: the in-flight operation is discarded, no response is issued, and all outputs take reset values immediately.
- Deasserting reset is synchronised by the system; the block needs no internal synchroniser.

Test Plan:
- Single request, NREQ=4, ALU_LAT=1:
  - Stimulus: req_valid=4'b0100, a=4'hF, b=4'h1, op=3'b000; resp_ready=1.
  - Response: req_ready=4'b0100 for exactly one cycle; alu_a=F, alu_b=1, alu_opcode=0 from the next cycle; resp_valid high 1 cycle after the handshake with resp_c=8'h10, resp_id=2; busy high for 2 cycles.
- Round-robin fairness:
  - Stimulus: all four requesters hold req_valid=1 continuously; resp_ready=1.
  - Response: grant order is 0,1,2,3,0,1; no requester is granted twice before the others.
- Wrap and skip:
  - Stimulus: after a grant to requester 3, req_valid=4'b1010.
  - Response: requester 1 is granted next, then requester 3.
- Response backpressure:
  - Stimulus: ALU_LAT=3, hold resp_ready=0 for 5 cycles after resp_valid rises; requester 0 is valid throughout.
  - Response: resp_c/resp_id stay stable; req_ready stays 0; the next grant occurs only in the cycle after resp_ready=1.
- Reset mid-operation:
  - Stimulus: assert reset in the second EXEC cycle (ALU_LAT=3).
  - Response: resp_valid never rises; outputs are 0 immediately; after release, requester 0 has priority again.
- Early withdrawal:
  - Stimulus: requester 2 raises req_valid while the block is in RESP, then drops it before the block returns to IDLE.
  - Response: no grant to requester 2; no spurious ALU issue.
